// File: rtl/branch_update_queue.sv
// -----------------------------------------------------------------------------
// branch_update_queue
//
// Buffers resolved-branch outcomes from the two SIC execution lanes and drains
// them in order, one per cycle, into the branch predictor's update port. This
// lets two branches resolve in the same cycle even though the predictor's BHT
// takes only one write per cycle.
//
// Parameters:
//   DEPTH   number of queue entries (power of 2, >= 2)
//   DROP_W  width of the saturating drop counter
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst_n         asynchronous active-low reset
//   in_valid[1:0] per-lane resolved-branch strobe, lane 0 older than lane 1
//   in_pc[1:0]    per-lane branch PC
//   in_taken[1:0] per-lane actual branch outcome
//   in_ready      at least two free slots this cycle (both lanes accepted)
//   update_en     update_pc / actual_taken carry a valid update this cycle
//   update_pc     PC of the head entry
//   actual_taken  outcome of the head entry
//   count         current occupancy
//   drop_cnt      saturating count of resolutions discarded while not ready
//
// Optional feature (macro BRANCH_UPDATE_BYPASS_EN):
//   When defined and the queue is empty, a valid lane 0 is forwarded
//   combinationally to the update port in the same cycle and is not stored.
//   Lane 1 is still stored and drains on the following cycle.
// -----------------------------------------------------------------------------
module branch_update_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             in_valid,
    input  logic [1:0][31:0]       in_pc,
    input  logic [1:0]             in_taken,
    output logic                   in_ready,
    output logic                   update_en,
    output logic [31:0]            update_pc,
    output logic                   actual_taken,
    output logic [$clog2(DEPTH):0] count,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned DW1 = DROP_W + 1;

    logic [31:0]   pc_mem    [DEPTH];
    logic          taken_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          head_valid;
    logic          bypass_hit;
    logic          we0;
    logic          we1;
    logic          pop;
    logic [PW-1:0] wr_addr1;
    logic [1:0]    num_push;
    logic [1:0]    num_drop;
    logic [CW-1:0] count_next;
    logic [DW1-1:0] drop_sum;

    assign head_valid = (count != '0);

    // Ready looks only at the registered occupancy; a same-cycle pop does not
    // free a slot for this cycle's push.
    assign in_ready = (count <= CW'(DEPTH - 2));

`ifdef BRANCH_UPDATE_BYPASS_EN
    assign bypass_hit = !head_valid && in_valid[0];
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        we0        = in_ready && in_valid[0] && !bypass_hit;
        we1        = in_ready && in_valid[1];
        // Lane 1 lands directly behind lane 0 only when lane 0 is stored.
        wr_addr1   = we0 ? (wr_ptr + PW'(1)) : wr_ptr;
        num_push   = {1'b0, we0} + {1'b0, we1};
        num_drop   = in_ready ? 2'd0 : ({1'b0, in_valid[0]} + {1'b0, in_valid[1]});
        // The predictor has no back-pressure: any stored head is consumed.
        pop        = head_valid;
        count_next = count + CW'(num_push) - CW'(pop);
        drop_sum   = {1'b0, drop_cnt} + DW1'(num_drop);
    end

    always_comb begin
        update_en    = head_valid;
        update_pc    = pc_mem[rd_ptr];
        actual_taken = taken_mem[rd_ptr];
        if (bypass_hit) begin
            update_en    = 1'b1;
            update_pc    = in_pc[0];
            actual_taken = in_taken[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                taken_mem[i] <= 1'b0;
            end
        end else begin
            if (we0) begin
                pc_mem[wr_ptr]    <= in_pc[0];
                taken_mem[wr_ptr] <= in_taken[0];
            end
            if (we1) begin
                pc_mem[wr_addr1]    <= in_pc[1];
                taken_mem[wr_addr1] <= in_taken[1];
            end
            wr_ptr <= wr_ptr + PW'(num_push);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count_next;
            drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
`timescale 1ns/1ps
module tb_branch_update_queue;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned DROP_W   = 8;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;
    localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [1:0]        in_valid = '0;
    logic [1:0][31:0]  in_pc    = '0;
    logic [1:0]        in_taken = '0;
    logic              in_ready;
    logic              update_en;
    logic [31:0]       update_pc;
    logic              actual_taken;
    logic [CW-1:0]     count;
    logic [DROP_W-1:0] drop_cnt;

    branch_update_queue #(
        .DEPTH (DEPTH),
        .DROP_W(DROP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_taken    (in_taken),
        .in_ready    (in_ready),
        .update_en   (update_en),
        .update_pc   (update_pc),
        .actual_taken(actual_taken),
        .count       (count),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an unbounded queue of pending updates plus a drop tally.
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } ent_t;

    ent_t        q[$];
    int unsigned m_drop      = 0;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned ncmp        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs for a cycle are applied just after the rising edge.
    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic t0,
                         input logic [31:0] p1, input logic t1);
        @(posedge clk);
        #1;
        in_valid = v;
        in_pc[0] = p0;
        in_pc[1] = p1;
        in_taken = {t1, t0};
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Compare process: checks every cycle at the falling edge, then advances
    // the model by what the next rising edge must do.
    always @(negedge clk) begin : compare
        int unsigned n;
        bit          byp;
        bit          exp_rdy;
        int unsigned tally;
        vectors++;
        if (!rst_n) begin
            q.delete();
            m_drop = 0;
            chk("rst_update_en", 32'(update_en), 32'd0);
            chk("rst_update_pc", update_pc, 32'd0);
            chk("rst_actual_taken", 32'(actual_taken), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            n       = q.size();
            exp_rdy = (DEPTH - n) >= 2;
            byp     = 1'b0;
`ifdef BRANCH_UPDATE_BYPASS_EN
            byp     = (n == 0) && in_valid[0];
`endif
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("count", 32'(count), n);
            chk("drop_cnt", 32'(drop_cnt), m_drop);
            if (n != 0) begin
                chk("update_en", 32'(update_en), 32'd1);
                chk("update_pc", update_pc, q[0].pc);
                chk("actual_taken", 32'(actual_taken), 32'(q[0].taken));
            end else if (byp) begin
                chk("bypass_en", 32'(update_en), 32'd1);
                chk("bypass_pc", update_pc, in_pc[0]);
                chk("bypass_taken", 32'(actual_taken), 32'(in_taken[0]));
            end else begin
                chk("update_en_idle", 32'(update_en), 32'd0);
            end

            if (n != 0) void'(q.pop_front());
            if (exp_rdy) begin
                if (in_valid[0] && !byp) q.push_back(ent_t'{pc: in_pc[0], taken: in_taken[0]});
                if (in_valid[1])         q.push_back(ent_t'{pc: in_pc[1], taken: in_taken[1]});
            end else begin
                tally  = m_drop + 32'(in_valid[0]) + 32'(in_valid[1]);
                m_drop = (tally > DROP_MAX) ? DROP_MAX : tally;
            end
        end
    end

    initial begin : stim
        bit         hit;
        logic [1:0] v;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single lane-0 branch.
        drive(2'b01, 32'h0040_0010, 1'b1, 32'h0, 1'b0);
`ifdef BRANCH_UPDATE_BYPASS_EN
        #1;
        chk("t1_en", 32'(update_en), 32'd1);
        chk("t1_pc", update_pc, 32'h0040_0010);
        chk("t1_taken", 32'(actual_taken), 32'd1);
`endif
        idle();
`ifndef BRANCH_UPDATE_BYPASS_EN
        #1;
        chk("t1_en", 32'(update_en), 32'd1);
        chk("t1_pc", update_pc, 32'h0040_0010);
        chk("t1_taken", 32'(actual_taken), 32'd1);
`endif
        idle();
        #1;
        chk("t1_en_after", 32'(update_en), 32'd0);
        chk("t1_count_after", 32'(count), 32'd0);

        // Two lanes in one cycle drain in lane order.
        drive(2'b11, 32'h100, 1'b0, 32'h104, 1'b1);
`ifdef BRANCH_UPDATE_BYPASS_EN
        #1;
        chk("t2_first_pc", update_pc, 32'h100);
        chk("t2_first_taken", 32'(actual_taken), 32'd0);
`endif
        idle();
        #1;
`ifdef BRANCH_UPDATE_BYPASS_EN
        chk("t2_second_pc", update_pc, 32'h104);
        chk("t2_second_taken", 32'(actual_taken), 32'd1);
`else
        chk("t2_first_pc", update_pc, 32'h100);
        chk("t2_first_taken", 32'(actual_taken), 32'd0);
`endif
        idle();
`ifndef BRANCH_UPDATE_BYPASS_EN
        #1;
        chk("t2_second_pc", update_pc, 32'h104);
        chk("t2_second_taken", 32'(actual_taken), 32'd1);
`endif
        repeat (2) idle();

        // Sustained dual-lane pressure: fills, drops in pairs, pointers wrap.
        for (int k = 0; k < 10; k++) begin
            drive(2'b11, 32'h200 + 32'(8 * k), 1'(k), 32'h204 + 32'(8 * k), ~1'(k));
        end
        idle();
        #1;
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd4);
        repeat (10) idle();

        // Drop counter saturation.
        for (int k = 0; k < 300; k++) begin
            drive(2'b11, $urandom & 32'hFFFF_FFFC, 1'($urandom),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom));
        end
        idle();
        #1;
        chk("t4_drop_sat", 32'(drop_cnt), 32'd255);

        // Asynchronous reset with five entries queued.
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            idle();
            if (q.size() == 5) hit = 1'b1;
        end
        if (!hit) begin
            miscompares++;
            $display("FAIL t5_wait_count5: got occupancy %0d, expected 5 within 20 cycles", q.size());
        end
        #1;
        chk("t5_pre_count", 32'(count), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("t5_async_en", 32'(update_en), 32'd0);
        chk("t5_async_count", 32'(count), 32'd0);
        chk("t5_async_drop", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) idle();

        // Empty queue, both lanes.
        drive(2'b11, 32'h300, 1'b1, 32'h304, 1'b0);
`ifdef BRANCH_UPDATE_BYPASS_EN
        #1;
        chk("t6_first_pc", update_pc, 32'h300);
        chk("t6_first_taken", 32'(actual_taken), 32'd1);
        chk("t6_first_count", 32'(count), 32'd0);
`endif
        idle();
        #1;
`ifdef BRANCH_UPDATE_BYPASS_EN
        chk("t6_second_pc", update_pc, 32'h304);
        chk("t6_second_taken", 32'(actual_taken), 32'd0);
        chk("t6_second_count", 32'(count), 32'd1);
`else
        chk("t6_first_pc", update_pc, 32'h300);
        chk("t6_first_taken", 32'(actual_taken), 32'd1);
`endif
        idle();
`ifndef BRANCH_UPDATE_BYPASS_EN
        #1;
        chk("t6_second_pc", update_pc, 32'h304);
        chk("t6_second_taken", 32'(actual_taken), 32'd0);
`endif
        repeat (2) idle();

        // Randomized traffic in phases of differing density.
        for (int c = 0; c < 2000; c++) begin
            case ((c / 200) % 3)
                0:       v = 2'($urandom_range(0, 3));
                1:       v = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
                default: v = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 2)) : 2'b00;
            endcase
            drive(v, $urandom & 32'hFFFF_FFFC, 1'($urandom),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom));
        end
        repeat (12) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
Buffers resolved-branch outcomes from the SIC execution lanes and drains them, one per cycle and in order, into the branch predictor's update port (update_en / update_pc / actual_taken). It decouples up to two same-cycle resolutions from the predictor's single-write BHT. It sits between the SIC writeback/resolve logic and branch_predictor.

Parameters:
DEPTH, 8, number of queue entries; power of 2, at least 2.
DROP_W, 8, width of the saturating drop counter.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  2  per-lane resolved-branch strobe; lane 0 is older than lane 1.
in_pc  input  2x32  per-lane branch PC.
in_taken  input  2  per-lane actual branch outcome.
in_ready  output  1  queue can accept both lanes this cycle.
update_en  output  1  to predictor: the update on the other two outputs is valid this cycle.
update_pc  output  32  to predictor: PC of the head entry.
actual_taken  output  1  to predictor: outcome of the head entry.
count  output  $clog2(DEPTH)+1  current occupancy.
drop_cnt  output  DROP_W  saturating count of discarded resolutions.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc[31:0], taken}, with wr_ptr and rd_ptr of width $clog2(DEPTH) that wrap naturally, plus count.
- Reset (asynchronous): wr_ptr, rd_ptr, count and drop_cnt go to 0; all entries go to 0. Outputs: update_en=0, update_pc=0, actual_taken=0, in_ready=1.
- Reset asserted mid-operation discards all queued entries; no update is emitted during reset.
- in_ready = ((DEPTH - count) >= 2). It is combinational from the registered count and ignores any same-cycle pop.
- Push, when in_ready=1:
  - each valid lane is written at posedge, lane 0 first;
  - lane 1 valid with lane 0 invalid writes a single entry;
  - count increases by the number of valid lanes.
- Drop: a lane valid while in_ready=0 is discarded and nothing is written. drop_cnt increases by the number of discarded lanes (0, 1 or 2) and saturates at 2^DROP_W-1.
- Drain:
  - update_en = (count != 0); update_pc and actual_taken come combinationally from entry[rd_ptr];
  - every cycle update_en=1 the head pops at posedge, because the predictor has no back-pressure;
  - throughput is one update per cycle.
- Latency: an entry pushed at edge N appears on the update outputs in the cycle after edge N, and is consumed at edge N+1 if it is at the head.
- Push and pop in the same cycle: count_next = count + pushes - pop. A full queue is impossible because in_ready guarantees at least 2 free slots before a push.
- Ordering: strict FIFO. Lane 0 precedes lane 1 within a cycle, and earlier cycles precede later ones. Duplicate PCs are not merged.

Optional Feature:
Macro: BRANCH_UPDATE_BYPASS_EN.
- With it defined: when count==0 and in_valid[0]=1, lane 0 is driven combinationally onto update_en/update_pc/actual_taken in the same cycle and is not stored. Lane 1, if valid, is stored and drains the next cycle. in_ready is unchanged.
- Without it: every entry passes through storage with 1-cycle latency, as described above.

Test Plan:
1. Reset, then lane 0 only {pc=0x0040_0010, taken=1} for one cycle -> in the next cycle update_en=1, update_pc=0x0040_0010, actual_taken=1 for exactly one cycle; count returns to 0.
2. Both lanes in one cycle {0x100, taken 0} and {0x104, taken 1} -> updates on two consecutive cycles, 0x100/0 then 0x104/1.
3. DEPTH=8: both lanes valid every cycle for 10 cycles with PCs 0x200+4k -> in_ready falls to 0 when count reaches 7; rejected lanes increase drop_cnt by 2 per cycle; accepted PCs are emitted in exact order with no gaps; pointers wrap correctly.
4. Saturation: force more than 255 dropped lanes with DROP_W=8 -> drop_cnt holds at 255.
5. Assert rst_n low asynchronously while count=5 -> update_en, count and drop_cnt are 0 immediately, before the next clock edge; no stale entries emerge after release.
6. BRANCH_UPDATE_BYPASS_EN with the queue empty, lane 0 {0x300, taken 1} and lane 1 {0x304, taken 0} -> same cycle update 0x300/1; next cycle update 0x304/0; count never exceeds 1.
